// File: rtl/dynamic_adder_pkg.sv
// Shared types for the dynamic ripple-carry adder: FSM state encoding and
// the width helper for the settle-cycle counter.
package dynamic_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

  // Worst-case count is ceil(n/k)+1; n/k+3 leaves headroom for the rounding.
  function automatic int cycle_width(input int n, input int k);
    return $clog2(n / k + 3);
  endfunction

endpackage

// File: rtl/dynamic_rca_carry_step.sv
// K chained ripple iterations of the carry vector in one clock; bit 0 is
// always re-pinned to the latched carry-in.
module carry_step #(
  parameter int N = 8,
  parameter int K = 1
) (
  input  logic [N-1:0] p,
  input  logic [N-1:0] g,
  input  logic [N:0]   c,
  input  logic         cin,
  output logic [N:0]   c_new
);

  logic [N:0] c_iter;

  always_comb begin
    c_iter = c;
    for (int k = 0; k < K; k++) begin
      c_iter = {g | (p & c_iter[N-1:0]), cin};
    end
    c_new = c_iter;
  end

endmodule

// File: rtl/dynamic_rca.sv
// Self-timed ripple-carry adder: carries ripple K stages per enabled cycle
// until the carry vector stops changing, then the sum is registered.
module dynamic_rca
  import dynamic_adder_pkg::*;
#(
  parameter int N  = 8,
  parameter int K  = 1,
  parameter int CW = cycle_width(N, K)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  A,
  input  logic [N-1:0]  B,
  input  logic          Cin,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  S,
  output logic [N-1:0]  P,
  output logic          Cout,
  output logic [CW-1:0] cycles
);

  state_t        state, state_nxt;
  logic [N-1:0]  p_q, g_q;
  logic          cin_q;
  logic [N:0]    c_q, c_new;
  logic [CW-1:0] cnt;
  logic          settled;

  carry_step #(.N(N), .K(K)) u_carry_step (
    .p     (p_q),
    .g     (g_q),
    .c     (c_q),
    .cin   (cin_q),
    .c_new (c_new)
  );

  assign settled   = (c_new == c_q);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = EVAL;
      EVAL:    if (enable && settled) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      p_q    <= '0;
      g_q    <= '0;
      cin_q  <= 1'b0;
      c_q    <= '0;
      cnt    <= '0;
      S      <= '0;
      P      <= '0;
      Cout   <= 1'b0;
      cycles <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            p_q   <= A ^ B;
            g_q   <= A & B;
            cin_q <= Cin;
            // Generates are pre-seeded so the first iteration only has to ripple.
            c_q   <= {A & B, Cin};
            cnt   <= '0;
          end
        end
        EVAL: begin
          if (enable) begin
            cnt <= cnt + 1'b1;
            if (settled) begin
              S      <= p_q ^ c_q[N-1:0];
              P      <= p_q;
              Cout   <= c_q[N];
              cycles <= cnt + 1'b1;
            end else begin
              c_q <= c_new;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dynamic_rca.sv
// Bench for dynamic_rca: six parameter configurations share one stimulus
// stream; per-instance queues hold expected results until the handshake.
module tb_dynamic_rca;

  localparam int NCFG = 6;
  localparam int CN [NCFG] = '{8, 8, 8, 32, 32, 32};
  localparam int CK [NCFG] = '{1, 2, 3, 1, 3, 32};

  typedef struct packed {
    logic [31:0] s;
    logic [31:0] p;
    logic        c;
    logic [7:0]  cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, enable, in_valid, cin, out_ready;
  logic [31:0] a, b;
  logic [31:0] s_o   [NCFG];
  logic [31:0] p_o   [NCFG];
  logic [7:0]  cyc_o [NCFG];
  logic        cout_o[NCFG];
  logic        ir_o  [NCFG];
  logic        ov_o  [NCFG];
  exp_t        exp_q [NCFG][$];
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NCFG; gi++) begin : g_dut
    localparam int NN  = CN[gi];
    localparam int KK  = CK[gi];
    localparam int CWW = $clog2(NN / KK + 3);
    logic [NN-1:0]  s_w, p_w;
    logic [CWW-1:0] cyc_w;
    dynamic_rca #(.N(NN), .K(KK)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .in_valid  (in_valid),
      .in_ready  (ir_o[gi]),
      .A         (a[NN-1:0]),
      .B         (b[NN-1:0]),
      .Cin       (cin),
      .out_valid (ov_o[gi]),
      .out_ready (out_ready),
      .S         (s_w),
      .P         (p_w),
      .Cout      (cout_o[gi]),
      .cycles    (cyc_w)
    );
    assign s_o[gi]   = 32'(s_w);
    assign p_o[gi]   = 32'(p_w);
    assign cyc_o[gi] = 8'(cyc_w);
  end

  // Reference: plain addition for the sum; cycle count from the longest run
  // of propagate bits that sits directly above an initial carry source.
  function automatic exp_t model(input int n, input int k,
                                 input logic [31:0] av, input logic [31:0] bv,
                                 input logic ci);
    exp_t        r;
    logic [63:0] mask, sum;
    logic [31:0] pv, gv;
    logic [32:0] src;
    int          lmax, len;
    mask = (64'd1 << n) - 64'd1;
    pv   = (av ^ bv) & mask[31:0];
    gv   = (av & bv) & mask[31:0];
    sum  = (64'(av) & mask) + (64'(bv) & mask) + 64'(ci);
    src  = {gv, ci};
    lmax = 0;
    for (int j = 0; j < n; j++) begin
      if (src[j]) begin
        len = 0;
        for (int q = j; q < n; q++) begin
          if (!pv[q]) break;
          len++;
        end
        if (len > lmax) lmax = len;
      end
    end
    r.s   = sum[31:0] & mask[31:0];
    r.p   = pv;
    r.c   = sum[n];
    r.cyc = 8'((lmax + k - 1) / k + 1);
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; in_valid = 1'b0; enable = 1'b1; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    tick; tick;
    rst = 1'b0;
    for (int i = 0; i < NCFG; i++) exp_q[i].delete();
  endtask

  task automatic apply_op(input logic [31:0] av, input logic [31:0] bv, input logic ci);
    a = av; b = bv; cin = ci; in_valid = 1'b1;
    for (int i = 0; i < NCFG; i++)
      if (ir_o[i]) exp_q[i].push_back(model(CN[i], CK[i], av, bv, ci));
    tick;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int idx, output int lat);
    lat = 0;
    while (!ov_o[idx] && lat < 100) begin
      tick;
      lat++;
    end
  endtask

  task automatic handshake;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; enable = 1'b1;
    a = 32'hFF; b = 32'h01; cin = 1'b1;
    tick;
    n_vec++;
    if (ir_o[0] !== 1'b1 || ov_o[0] !== 1'b0) begin
      n_err++;
      $display("FAIL reset_first_cycle: in_ready=%b out_valid=%b, want 1/0", ir_o[0], ov_o[0]);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    tick;
    rst = 1'b0;
    for (int i = 0; i < NCFG; i++) begin
      n_vec++;
      if (ir_o[i] !== 1'b1 || ov_o[i] !== 1'b0 || s_o[i] !== 32'd0 || p_o[i] !== 32'd0 ||
          cout_o[i] !== 1'b0 || cyc_o[i] !== 8'd0) begin
        n_err++;
        $display("FAIL reset_state[%0d]: ir=%b ov=%b S=%h P=%h Cout=%b cycles=%0d, want 1 0 0 0 0 0",
                 i, ir_o[i], ov_o[i], s_o[i], p_o[i], cout_o[i], cyc_o[i]);
      end
    end
  endtask

  task automatic test_zero;
    int   lat;
    exp_t e;
    do_reset;
    apply_op(32'h00, 32'h00, 1'b0);
    wait_done(0, lat);
    e = exp_q[0].pop_front();
    n_vec++;
    if (lat !== 1 || s_o[0] !== 32'h00 || cout_o[0] !== 1'b0 || cyc_o[0] !== 8'd1 ||
        s_o[0] !== e.s || cyc_o[0] !== e.cyc) begin
      n_err++;
      $display("FAIL zero_add: lat=%0d S=%h Cout=%b cycles=%0d, want lat=1 S=00 Cout=0 cycles=1",
               lat, s_o[0], cout_o[0], cyc_o[0]);
    end
    handshake;
    n_vec++;
    if (ir_o[0] !== 1'b1 || ov_o[0] !== 1'b0) begin
      n_err++;
      $display("FAIL zero_release: in_ready=%b out_valid=%b, want 1/0", ir_o[0], ov_o[0]);
    end
  endtask

  task automatic test_carry_chain;
    int   lat0, lat1;
    exp_t e0, e1;
    do_reset;
    apply_op(32'hFF, 32'h01, 1'b0);
    lat0 = -1; lat1 = -1;
    for (int t = 1; t <= 100 && (lat0 < 0 || lat1 < 0); t++) begin
      tick;
      if (lat0 < 0 && ov_o[0]) lat0 = t;
      if (lat1 < 0 && ov_o[1]) lat1 = t;
    end
    e0 = exp_q[0].pop_front();
    e1 = exp_q[1].pop_front();
    n_vec++;
    if (lat0 !== 8 || s_o[0] !== 32'h00 || cout_o[0] !== 1'b1 || p_o[0] !== 32'hFE ||
        cyc_o[0] !== 8'd8 || cyc_o[0] !== e0.cyc) begin
      n_err++;
      $display("FAIL chain_k1: lat=%0d S=%h Cout=%b P=%h cycles=%0d, want 8 00 1 FE 8",
               lat0, s_o[0], cout_o[0], p_o[0], cyc_o[0]);
    end
    n_vec++;
    if (lat1 !== 5 || s_o[1] !== 32'h00 || cout_o[1] !== 1'b1 || p_o[1] !== 32'hFE ||
        cyc_o[1] !== 8'd5 || cyc_o[1] !== e1.cyc) begin
      n_err++;
      $display("FAIL chain_k2: lat=%0d S=%h Cout=%b P=%h cycles=%0d, want 5 00 1 FE 5",
               lat1, s_o[1], cout_o[1], p_o[1], cyc_o[1]);
    end
    handshake;
  endtask

  task automatic test_worst_enable;
    int lat;
    do_reset;
    apply_op(32'h0F, 32'hF0, 1'b1);
    wait_done(0, lat);
    n_vec++;
    if (lat !== 9 || s_o[0] !== 32'h00 || cout_o[0] !== 1'b1 || cyc_o[0] !== 8'd9) begin
      n_err++;
      $display("FAIL worst_case: lat=%0d S=%h Cout=%b cycles=%0d, want 9 00 1 9",
               lat, s_o[0], cout_o[0], cyc_o[0]);
    end
    void'(exp_q[0].pop_front());
    handshake;
    apply_op(32'h0F, 32'hF0, 1'b1);
    enable = 1'b0;
    tick; tick; tick;
    enable = 1'b1;
    wait_done(0, lat);
    n_vec++;
    if (lat + 3 !== 12 || s_o[0] !== 32'h00 || cout_o[0] !== 1'b1 || cyc_o[0] !== 8'd9) begin
      n_err++;
      $display("FAIL worst_stalled: lat=%0d S=%h Cout=%b cycles=%0d, want 12 00 1 9",
               lat + 3, s_o[0], cout_o[0], cyc_o[0]);
    end
    handshake;
  endtask

  task automatic test_hold;
    int   lat;
    exp_t e;
    do_reset;
    apply_op(32'h12, 32'h34, 1'b0);
    wait_done(0, lat);
    e = exp_q[0].pop_front();
    for (int t = 0; t < 5; t++) begin
      out_ready = 1'b0;
      in_valid  = t[0];
      a = $urandom; b = $urandom; cin = 1'($urandom_range(1));
      tick;
      n_vec++;
      if (s_o[0] !== 32'h46 || s_o[0] !== e.s || p_o[0] !== e.p || cout_o[0] !== 1'b0 ||
          cyc_o[0] !== e.cyc || ov_o[0] !== 1'b1 || ir_o[0] !== 1'b0) begin
        n_err++;
        $display("FAIL hold[%0d]: S=%h P=%h Cout=%b cycles=%0d ov=%b ir=%b, want 46 %h 0 %0d 1 0",
                 t, s_o[0], p_o[0], cout_o[0], cyc_o[0], ov_o[0], ir_o[0], e.p, e.cyc);
      end
    end
    out_ready = 1'b1; in_valid = 1'b1; a = 32'h01; b = 32'h01; cin = 1'b0;
    tick;
    in_valid = 1'b0; out_ready = 1'b0;
    n_vec++;
    if (ir_o[0] !== 1'b1 || ov_o[0] !== 1'b0) begin
      n_err++;
      $display("FAIL hold_release: in_ready=%b out_valid=%b, want 1/0", ir_o[0], ov_o[0]);
    end
  endtask

  task automatic test_reset_mid_eval;
    int   lat;
    exp_t e;
    do_reset;
    apply_op(32'h12, 32'h34, 1'b0);
    wait_done(0, lat);
    void'(exp_q[0].pop_front());
    handshake;
    apply_op(32'hFF, 32'h01, 1'b0);
    tick; tick; tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    for (int i = 0; i < NCFG; i++) exp_q[i].delete();
    n_vec++;
    if (ir_o[0] !== 1'b1 || ov_o[0] !== 1'b0 || s_o[0] !== 32'd0 || p_o[0] !== 32'd0 ||
        cout_o[0] !== 1'b0 || cyc_o[0] !== 8'd0) begin
      n_err++;
      $display("FAIL reset_mid_eval: ir=%b ov=%b S=%h P=%h Cout=%b cycles=%0d, want 1 0 0 0 0 0",
               ir_o[0], ov_o[0], s_o[0], p_o[0], cout_o[0], cyc_o[0]);
    end
    apply_op(32'h12, 32'h34, 1'b0);
    wait_done(0, lat);
    e = exp_q[0].pop_front();
    n_vec++;
    if (!ov_o[0] || s_o[0] !== 32'h46 || cout_o[0] !== 1'b0 || cyc_o[0] !== e.cyc) begin
      n_err++;
      $display("FAIL after_reset_add: ov=%b S=%h Cout=%b cycles=%0d, want 1 46 0 %0d",
               ov_o[0], s_o[0], cout_o[0], cyc_o[0], e.cyc);
    end
    handshake;
  endtask

  task automatic test_random;
    int   ops, drain;
    exp_t e;
    do_reset;
    ops = 0; drain = 0;
    for (int t = 0; t < 60000 && drain < 80; t++) begin
      if (ops >= 10000) begin
        in_valid = 1'b0; enable = 1'b1; out_ready = 1'b1;
        drain++;
      end else begin
        enable    = ($urandom_range(3) != 0);
        out_ready = ($urandom_range(3) != 0);
        in_valid  = ($urandom_range(3) != 0);
        cin       = 1'($urandom_range(1));
        a         = $urandom;
        case ($urandom_range(3))
          0: b = $urandom;
          1: b = ~a;
          2: b = ~a ^ (32'd1 << $urandom_range(31));
          default: begin a = 32'hFFFF_FFFF; b = $urandom_range(3); end
        endcase
      end
      for (int i = 0; i < NCFG; i++) begin
        if (ov_o[i] && out_ready) begin
          n_vec++;
          if (exp_q[i].size() == 0) begin
            n_err++;
            $display("FAIL rand_unexpected[%0d]: out_valid with S=%h, want no result pending", i, s_o[i]);
          end else begin
            e = exp_q[i].pop_front();
            ops++;
            if (s_o[i] !== e.s || p_o[i] !== e.p || cout_o[i] !== e.c || cyc_o[i] !== e.cyc) begin
              n_err++;
              $display("FAIL rand_result[%0d]: S=%h P=%h Cout=%b cycles=%0d, want %h %h %b %0d",
                       i, s_o[i], p_o[i], cout_o[i], cyc_o[i], e.s, e.p, e.c, e.cyc);
            end
            n_vec++;
            if (cyc_o[i] > 8'((CN[i] + CK[i] - 1) / CK[i] + 1) || cyc_o[i] == 8'd0) begin
              n_err++;
              $display("FAIL rand_cycle_bound[%0d]: cycles=%0d, want 1..%0d",
                       i, cyc_o[i], (CN[i] + CK[i] - 1) / CK[i] + 1);
            end
          end
        end
        if (in_valid && ir_o[i]) exp_q[i].push_back(model(CN[i], CK[i], a, b, cin));
      end
      tick;
    end
    n_vec++;
    if (ops < 10000) begin
      n_err++;
      $display("FAIL rand_op_count: completed %0d, want at least 10000", ops);
    end
    for (int i = 0; i < NCFG; i++) begin
      n_vec++;
      if (exp_q[i].size() != 0) begin
        n_err++;
        $display("FAIL rand_drain[%0d]: %0d results outstanding, want 0", i, exp_q[i].size());
      end
    end
  endtask

  initial begin
    test_reset;
    test_zero;
    test_carry_chain;
    test_worst_enable;
    test_hold;
    test_reset_mid_eval;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
